// File: rtl/seq_arith_32b_add_serial.sv
// ---------------------------------------------------------------------------
// seq_arith_32b_add_serial
//
// Bit-serial-by-byte 32-bit adder: {cout,out} = in0 + in1 + cin, computed one
// 8-bit add-with-carry slice per clock, least-significant byte first. A
// valid/ready handshake on each side; one operation in flight at a time.
//
// Optional feature (macro SEQ_ADD_OVERFLOW_EN): adds output ovf, the signed
// two's-complement overflow flag, registered alongside cout.
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous active-high reset
//   in_val   in   1   operands valid
//   in_rdy   out  1   block can accept operands (IDLE)
//   in0      in   32  operand A
//   in1      in   32  operand B
//   cin      in   1   carry-in to bit 0
//   out_val  out  1   result valid (DONE)
//   out_rdy  in   1   consumer accepts result
//   out      out  32  registered sum
//   ovf      out  1   signed overflow (only with SEQ_ADD_OVERFLOW_EN)
//   cout     out  1   registered carry-out of bit 31
// ---------------------------------------------------------------------------
module seq_arith_32b_add_serial (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        cin,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out,
`ifdef SEQ_ADD_OVERFLOW_EN
    output logic        ovf,
`endif
    output logic        cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_out;
    logic        r_cout;
    logic        r_out_val;
    logic        r_in_rdy;
`ifdef SEQ_ADD_OVERFLOW_EN
    logic        r_ovf;
`endif

    logic [7:0]  w_byte_a;
    logic [7:0]  w_byte_b;
    logic [7:0]  w_sum;
    logic        w_c;

    // Byte slice selected by the current index; the carry between slices
    // travels only through r_carry, so there is no input-to-output path.
    assign w_byte_a = r_a[{r_idx, 3'b000} +: 8];
    assign w_byte_b = r_b[{r_idx, 3'b000} +: 8];
    assign {w_c, w_sum} = {1'b0, w_byte_a} + {1'b0, w_byte_b} + {8'd0, r_carry};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_out     <= '0;
            r_cout    <= 1'b0;
            r_out_val <= 1'b0;
            r_in_rdy  <= 1'b1;
`ifdef SEQ_ADD_OVERFLOW_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_val) begin
                        r_a      <= in0;
                        r_b      <= in1;
                        r_carry  <= cin;
                        r_idx    <= '0;
                        r_in_rdy <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_out[{r_idx, 3'b000} +: 8] <= w_sum;
                    r_carry <= w_c;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_cout    <= w_c;
`ifdef SEQ_ADD_OVERFLOW_EN
                        // w_sum[7] is bit 31 of the final sum.
                        r_ovf     <= (r_a[31] == r_b[31]) && (w_sum[7] != r_a[31]);
`endif
                        r_out_val <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // in_rdy stays low in the handshake cycle; the next accept
                    // can only happen from IDLE on the following edge.
                    if (out_rdy) begin
                        r_out_val <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_out_val <= 1'b0;
                    r_in_rdy  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign in_rdy  = r_in_rdy;
    assign out_val = r_out_val;
    assign out     = r_out;
    assign cout    = r_cout;
`ifdef SEQ_ADD_OVERFLOW_EN
    assign ovf     = r_ovf;
`endif

endmodule

// File: doc/seq_arith_32b_add_serial.md
SEQ_ARITH_32B_ADD_SERIAL -- requirements
Module: seq_arith_32b_add_serial

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_val  input  1  input operands valid.
REQ-005 in_rdy  output  1  block can accept operands.
REQ-006 in0  input  32  operand A.
REQ-007 in1  input  32  operand B.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 out_val  output  1  result valid.
REQ-010 out_rdy  input  1  consumer accepts result.
REQ-011 out  output  32  registered sum, bits 31:0.
REQ-012 cout  output  1  registered carry-out of bit 31.

Function
REQ-013 The block SHALL compute {cout,out} = in0 + in1 + cin using one 8-bit add-with-carry slice per cycle, four slices in total, least-significant byte first.
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 IDLE: in_rdy=1, out_val=0. On in_val=1 the block SHALL capture in0, in1 and cin into registers, clear the byte index to 0, and move to CALC.
REQ-016 CALC: in_rdy=0, out_val=0. Each cycle the block SHALL compute {c,s} = A[idx] + B[idx] + carry_reg, where A[idx] and B[idx] are bytes, write s to result byte idx, set carry_reg=c, and increment idx.
REQ-017 CALC SHALL last exactly 4 cycles. On the cycle with idx=3 the block SHALL move to DONE.
REQ-018 Latency: out_val SHALL rise exactly 4 cycles after the accepting edge (in_val && in_rdy).
REQ-019 DONE: out_val=1, in_rdy=0. out and cout SHALL hold stable until out_rdy=1. When out_rdy=1 the block SHALL return to IDLE.
REQ-020 A new input SHALL NOT be accepted in the cycle the output handshake occurs. The earliest next accept SHALL be the following cycle in IDLE. The maximum rate is therefore one operation per 6 cycles.
REQ-021 in_val SHALL be ignored and the captured operands left unchanged while the block is in CALC or DONE.
REQ-022 out and cout SHALL keep the last result after returning to IDLE, until the next operation overwrites them during CALC.
REQ-023 Carry SHALL ripple across byte boundaries through carry_reg only. No combinational path SHALL exist from the inputs to out or cout.

Reset
REQ-024 Reset SHALL force the following values immediately and asynchronously: FSM=IDLE, idx=0, carry_reg=0, operand registers=0, out=0x00000000, cout=0, out_val=0, in_rdy=1.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation. No out_val pulse SHALL be produced for the aborted operation.

Configuration
REQ-026 Macro SEQ_ADD_OVERFLOW_EN: when defined, the block SHALL add the port ovf (output, 1 bit), registered together with cout. ovf SHALL be 1 iff in0[31]==in1[31] and out[31]!=in0[31] (signed two's-complement overflow). ovf SHALL reset to 0 and SHALL hold with out.
REQ-027 When SEQ_ADD_OVERFLOW_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Assert reset mid-cycle -> immediately out_val=0, in_rdy=1, out=0x00000000, cout=0.
REQ-029 Apply in0=0x000000FF, in1=0x00000001, cin=0 with out_rdy=1 -> out=0x00000100, cout=0, out_val high 4 cycles after accept.
REQ-030 Apply in0=0xFFFFFFFF, in1=0x00000000, cin=1 -> out=0x00000000, cout=1; carry propagates through all four bytes.
REQ-031 Apply in0=0x12345678, in1=0x11111111, cin=0 and hold out_rdy=0 for 3 cycles while in_val=1 with different data -> out=0x23456789 held stable, in_rdy=0, second operand not captured. After out_rdy=1 -> IDLE, and the second operand is accepted on the next cycle.
REQ-032 Pulse reset 2 cycles into CALC -> IDLE, out_val stays 0, and a following 0x1+0x1 operation yields out=0x00000002.
REQ-033 With SEQ_ADD_OVERFLOW_EN defined, apply 0x7FFFFFFF + 0x00000001, cin=0 -> out=0x80000000, cout=0, ovf=1. Apply 0xFFFFFFFF + 0x00000001 -> out=0, cout=1, ovf=0.
